tree_sum_accumulator: RTL
=========================

// Module: tree_sum_accumulator
// PURPOSE
// - Consumer end of the tree adder result stream (sum/addr_i/addr_k/val; no backpressure on that side).
// - Accumulates K_TILES partial sums per output row (addr_i) into ACC_WIDTH accumulators.
// - Queues each completed row in an output FIFO drained by a val/rdy handshake.
// - Raises stall_out early enough that upstream can stop issuing before in-flight results overflow the FIFO.
// PARAMETERS
// - DATA_WIDTH      8   width of incoming partial sum
// - ACC_WIDTH       16  accumulator / output width; must be >= DATA_WIDTH
// - ADDRESS_WIDTH_I 8   row address width
// - ADDRESS_WIDTH_K 8   k-tile address width
// - NUM_ROWS        16  accumulator entries, power of 2; indexed by addr_i[$clog2(NUM_ROWS)-1:0]
// - K_TILES         4   partials per row, 1..2**ADDRESS_WIDTH_K
// - FIFO_DEPTH      8   output FIFO entries, power of 2
// - PIPE_SLACK      5   upstream in-flight results (adder stages + 1); must be < FIFO_DEPTH
// PORTS
// - clk          in   1                clock
// - reset        in   1                asynchronous, active-high reset
// - sum_in       in   DATA_WIDTH       partial sum from tree adder
// - addr_i_in    in   ADDRESS_WIDTH_I  row address of partial
// - addr_k_in    in   ADDRESS_WIDTH_K  k-tile index of partial
// - val_in       in   1                partial valid; no ready, must be accepted every cycle
// - out_val      out  1                FIFO head valid
// - out_rdy      in   1                downstream accepts head
// - out_acc      out  ACC_WIDTH        completed row sum
// - out_addr_i   out  ADDRESS_WIDTH_I  completed row address
// - stall_out    out  1                upstream must not issue new work while high
// - overflow_err out  1                sticky: completion dropped, FIFO full
// - seq_err      out  1                sticky: non-first partial hit an idle row
// BEHAVIOUR
// - Reset (async, active-high):
//   - outputs: out_val, stall_out, overflow_err, seq_err = 0
//   - FIFO emptied; busy[] cleared; accumulator contents don't-care.
// - Partial handling, on val_in with idx = addr_i_in low bits:
//   - width: zero-extend sum_in to ACC_WIDTH; addition wraps mod 2**ACC_WIDTH.
//   - first (addr_k_in==0): acc[idx] <= ext(sum_in); busy[idx] <= 1.
//   - middle (0 < addr_k_in < K_TILES-1, or addr_k_in >= K_TILES): acc[idx] <= acc[idx] + ext(sum_in).
//   - last (addr_k_in==K_TILES-1): push {addr_i_in, acc[idx]+ext(sum_in)} to FIFO; busy[idx] <= 0.
//   - K_TILES==1: every partial is first and last; pushes ext(sum_in) directly.
//   - idle row: non-first partial with busy[idx]==0 -> seq_err <= 1. Data is still processed as middle/last
//     with the stale acc.
//   - back-to-back same row: read-modify-write sees the previous cycle's write.
// - Latency and handshake:
//   - latency: final partial at cycle N -> out_val=1 at N+1 (FIFO was empty).
//   - out_acc/out_addr_i stable while out_val && !out_rdy; pop on out_val && out_rdy.
//   - FIFO order = completion order.
// - FIFO boundary conditions:
//   - full + push + pop same cycle: accepted, count unchanged.
//   - full + push, no pop: entry dropped, overflow_err <= 1, FIFO unchanged.
//   - empty + push + out_rdy: no bypass; data appears next cycle.
// - stall_out: registered; 1 when count >= FIFO_DEPTH-PIPE_SLACK, 0 otherwise.
// - Sticky errors: cleared only by reset.
// - Reset mid-row: partial rows are discarded; post-reset partials for that row raise seq_err unless they
//   restart at addr_k==0.
// CONFIGURATION
// - TREE_SUM_ACC_SAT_EN defined:
//   - accumulate and last-sum saturate at {ACC_WIDTH{1'b1}} instead of wrapping.
//   - first partial is unaffected.
// - TREE_SUM_ACC_SAT_EN undefined: modular wrap as above.
// TESTING
// - T1 basic: K_TILES=4, row 3 gets 10,20,30,40 (k=0..3), out_rdy=1 -> one out_acc=100, out_addr_i=3,
//   one cycle after k=3.
// - T2 interleave: rows 1,2 alternate k=0..3 with sums 1 and 2 -> out (1,4) then (2,8), in completion order.
// - T3 backpressure: out_rdy=0, complete 8 rows -> stall_out=1 once count>=3; 9th completion drops,
//   overflow_err=1; then out_rdy=1 drains the 8 in order.
// - T4 wrap/sat: ACC_WIDTH=8, four partials of 255:
//   - macro off -> out_acc=252
//   - TREE_SUM_ACC_SAT_EN -> out_acc=255
// - T5 sequence error: first partial on idle row 5 with k=2 -> seq_err=1 next cycle and stays high.
// - T6 reset mid-op: reset asserted after k=1 of row 0 with FIFO holding 2 entries -> out_val=0, flags=0
//   immediately; new k=0..3 of 1 each -> out_acc=4.

Source files
------------

// File: rtl/tree_sum_accumulator_if.sv
// Partial-sum input stream and completed-row output stream of tree_sum_accumulator.
// master = producer/consumer side, slave = the accumulator.
interface tree_sum_accumulator_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int ACC_WIDTH       = 16,
    parameter int ADDRESS_WIDTH_I = 8,
    parameter int ADDRESS_WIDTH_K = 8
);
    logic [DATA_WIDTH-1:0]      sum_in;
    logic [ADDRESS_WIDTH_I-1:0] addr_i_in;
    logic [ADDRESS_WIDTH_K-1:0] addr_k_in;
    logic                       val_in;
    logic                       out_val;
    logic                       out_rdy;
    logic [ACC_WIDTH-1:0]       out_acc;
    logic [ADDRESS_WIDTH_I-1:0] out_addr_i;
    logic                       stall_out;

    modport master (
        output sum_in, addr_i_in, addr_k_in, val_in, out_rdy,
        input  out_val, out_acc, out_addr_i, stall_out
    );

    modport slave (
        input  sum_in, addr_i_in, addr_k_in, val_in, out_rdy,
        output out_val, out_acc, out_addr_i, stall_out
    );
endinterface

// File: rtl/tree_sum_accumulator.sv
// Accumulates K_TILES partial sums per row and queues finished rows in an output FIFO.
// Define TREE_SUM_ACC_SAT_EN to saturate accumulation instead of wrapping.
module tree_sum_accumulator #(
    parameter int DATA_WIDTH      = 8,
    parameter int ACC_WIDTH       = 16,
    parameter int ADDRESS_WIDTH_I = 8,
    parameter int ADDRESS_WIDTH_K = 8,
    parameter int NUM_ROWS        = 16,
    parameter int K_TILES         = 4,
    parameter int FIFO_DEPTH      = 8,
    parameter int PIPE_SLACK      = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    tree_sum_accumulator_if.slave   bus,
    output logic                    overflow_err,
    output logic                    seq_err
);
    localparam int IDX_W = $clog2(NUM_ROWS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDRESS_WIDTH_K-1:0] K_LAST   = ADDRESS_WIDTH_K'(K_TILES - 1);
    localparam logic [CNT_W-1:0]           DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]           STALL_TH = CNT_W'(FIFO_DEPTH - PIPE_SLACK);

    typedef struct packed {
        logic [ADDRESS_WIDTH_I-1:0] addr;
        logic [ACC_WIDTH-1:0]       acc;
    } entry_t;

    logic [ACC_WIDTH-1:0] acc_q [NUM_ROWS];
    logic [NUM_ROWS-1:0]  busy_q, busy_d;
    entry_t               fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 stall_q, ovf_q, ovf_d, seq_q, seq_d;

    logic [IDX_W-1:0]     idx;
    logic [ACC_WIDTH-1:0] ext, acc_rd, acc_sum, push_acc;
    logic                 is_first, is_last, push, pop, push_ok, out_val;

    assign idx    = bus.addr_i_in[IDX_W-1:0];
    assign ext    = ACC_WIDTH'(bus.sum_in);
    assign acc_rd = acc_q[idx];

`ifdef TREE_SUM_ACC_SAT_EN
    logic [ACC_WIDTH:0] acc_wide;
    assign acc_wide = {1'b0, acc_rd} + {1'b0, ext};
    assign acc_sum  = acc_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : acc_wide[ACC_WIDTH-1:0];
`else
    assign acc_sum  = acc_rd + ext;
`endif

    // With a single tile every partial both opens and closes its row.
    assign is_first = (K_TILES == 1) || (bus.addr_k_in == '0);
    assign is_last  = (K_TILES == 1) || (bus.addr_k_in == K_LAST);
    assign push_acc = is_first ? ext : acc_sum;

    assign out_val  = (cnt_q != '0);
    assign push     = bus.val_in && is_last;
    assign pop      = out_val && bus.out_rdy;
    assign push_ok  = push && ((cnt_q != DEPTH_C) || pop);

    always_comb begin
        busy_d   = busy_q;
        if (bus.val_in) begin
            if (is_last)       busy_d[idx] = 1'b0;
            else if (is_first) busy_d[idx] = 1'b1;
        end
        seq_d    = seq_q | (bus.val_in && !is_first && !busy_q[idx]);
        ovf_d    = ovf_q | (push && !push_ok);
        cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
            seq_q    <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            stall_q  <= (cnt_d >= STALL_TH);
            ovf_q    <= ovf_d;
            seq_q    <= seq_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by busy_q and the FIFO count.
    always_ff @(posedge clk) begin
        if (bus.val_in && !is_last)
            acc_q[idx] <= push_acc;
        if (push_ok)
            fifo_q[wr_ptr_q] <= '{addr: bus.addr_i_in, acc: push_acc};
    end

    assign bus.out_val    = out_val;
    assign bus.out_acc    = fifo_q[rd_ptr_q].acc;
    assign bus.out_addr_i = fifo_q[rd_ptr_q].addr;
    assign bus.stall_out  = stall_q;
    assign overflow_err   = ovf_q;
    assign seq_err        = seq_q;
endmodule
